// File: rtl/ipsxb_fft_pkg.sv
// -----------------------------------------------------------------------------
// ipsxb_fft_pkg
// Shared definitions for the FFT datapath blocks:
//   - clog2()          : ceiling log2 for sizing counters and pointers
//   - fft_len()        : frame length N from its LOGS_FFT_LEN encoding
//   - round_up_bytes() : rounds a component width up to whole bytes
//   - state_e          : framer FSM state encoding
// -----------------------------------------------------------------------------
package ipsxb_fft_pkg;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result++;
         rem = rem >> 1;
      end
      return result;
   endfunction

   // The FFT core takes its transform length as log2(N).
   function automatic int fft_len(input int logs_fft_len);
      return 1 << logs_fft_len;
   endfunction

   // AXI4-Stream components are carried in whole bytes.
   function automatic int round_up_bytes(input int width);
      return ((width + 7) / 8) * 8;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CFG  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

endpackage

// File: rtl/ipsxb_fft_adc_framer_if.sv
// -----------------------------------------------------------------------------
// ipsxb_fft_adc_framer_if
// Bundles the framer-to-FFT signals: the xn data stream (tvalid/tdata/tlast
// with tready back-pressure) and the ready-less config strobe.
//   master : framer side (drives data/config, samples tready)
//   slave  : FFT side    (samples data/config, drives tready)
// -----------------------------------------------------------------------------
interface ipsxb_fft_adc_framer_if #(
   parameter int DATA_W = 32
);
   logic              tvalid;
   logic [DATA_W-1:0] tdata;
   logic              tlast;
   logic              tready;
   logic              cfg_tvalid;
   logic              cfg_tdata;

   modport master (
      output tvalid, tdata, tlast, cfg_tvalid, cfg_tdata,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tlast, cfg_tvalid, cfg_tdata,
      output tready
   );
endinterface

// File: rtl/ipsxb_fft_sync_fifo.sv
// -----------------------------------------------------------------------------
// ipsxb_fft_sync_fifo
// Single-clock show-ahead FIFO: the head entry is always visible on rd_data
// while empty is low; rd_en pops it. Depth is 2^AW.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous return of both pointers to the reset position
//   wr_en/data : push (caller guarantees !full or a same-cycle pop)
//   rd_en      : pop  (caller guarantees !empty)
//   rd_data    : head entry
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module ipsxb_fft_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   // One extra pointer bit tells full from empty when the addresses match.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   // A write to a full FIFO lands in the slot being popped this same cycle;
   // the head is read combinationally before the edge, so nothing is lost.
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/ipsxb_fft_adc_framer.sv
// -----------------------------------------------------------------------------
// ipsxb_fft_adc_framer
// Frames a free-running real ADC stream for the FFT xn input: one forward
// config beat per frame, then 2^LOGS_FFT_LEN data beats ending in tlast.
//   i_aclk, i_aresetn      : clock, asynchronous active-low reset
//   i_run                  : level, keep producing frames
//   i_clr                  : pulse, clears o_ovf and o_frm_cnt
//   i_smp_valid/i_smp_data : ADC samples, no back-pressure
//   o_axi4s_data_*         : xn stream, real sign-extended in low half, imag 0
//   o_axi4s_cfg_*          : forward-FFT config strobe (no ready)
//   o_busy                 : FSM not idle
//   o_ovf                  : sticky sample-drop flag
//   o_frm_cnt              : completed frames, wraps
// -----------------------------------------------------------------------------
module ipsxb_fft_adc_framer
   import ipsxb_fft_pkg::*;
#(
   parameter int LOGS_FFT_LEN = 11,
   parameter int INPUT_WIDTH  = 16,
   parameter int FIFO_AW      = 5,
   parameter int DATAIN_WIDTH = 16
) (
   input  logic                      i_aclk,
   input  logic                      i_aresetn,
   input  logic                      i_run,
   input  logic                      i_clr,
   input  logic                      i_smp_valid,
   input  logic [INPUT_WIDTH-1:0]    i_smp_data,
   output logic                      o_axi4s_data_tvalid,
   output logic [2*DATAIN_WIDTH-1:0] o_axi4s_data_tdata,
   output logic                      o_axi4s_data_tlast,
   input  logic                      i_axi4s_data_tready,
   output logic                      o_axi4s_cfg_tvalid,
   output logic                      o_axi4s_cfg_tdata,
   output logic                      o_busy,
   output logic                      o_ovf,
   output logic [15:0]               o_frm_cnt
);
   localparam int                      FRAME_LEN = fft_len(LOGS_FFT_LEN);
   localparam logic [LOGS_FFT_LEN-1:0] CNT_LAST  = LOGS_FFT_LEN'(FRAME_LEN - 1);

   state_e                    state_q, state_d;
   logic [LOGS_FFT_LEN-1:0]   cnt_q, cnt_d;
   logic                      ovf_q, ovf_d;
   logic [15:0]               frm_cnt_q, frm_cnt_d;

   logic                      fifo_full, fifo_empty, fifo_wr_en;
   logic [INPUT_WIDTH-1:0]    fifo_rd_data;
   logic                      smp_req, smp_drop, data_hs, tlast_hs;
   logic signed [DATAIN_WIDTH-1:0] real_ext;

   // Samples are accepted from CFG onward so nothing is lost between frames.
   assign smp_req    = i_smp_valid && (state_q != ST_IDLE);
   assign data_hs    = o_axi4s_data_tvalid && i_axi4s_data_tready;
   assign tlast_hs   = data_hs && (cnt_q == CNT_LAST);
   assign fifo_wr_en = smp_req && (!fifo_full || data_hs);
   assign smp_drop   = smp_req && fifo_full && !data_hs;
   assign real_ext   = DATAIN_WIDTH'($signed(fifo_rd_data));

   ipsxb_fft_sync_fifo #(
      .WIDTH (INPUT_WIDTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (i_aclk),
      .rst_n   (i_aresetn),
      .flush   (state_q == ST_IDLE),
      .wr_en   (fifo_wr_en),
      .wr_data (i_smp_data),
      .rd_en   (data_hs),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // State register.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   // Next state: a frame, once started, always runs to its tlast.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (i_run) state_d = ST_CFG;
         ST_CFG:  state_d = ST_DATA;
         ST_DATA: if (tlast_hs) state_d = i_run ? ST_CFG : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs. tdata is gated by tvalid so the unreset FIFO storage never leaks.
   always_comb begin
      o_busy              = (state_q != ST_IDLE);
      o_axi4s_cfg_tvalid  = (state_q == ST_CFG);
      o_axi4s_cfg_tdata   = (state_q == ST_CFG);
      o_axi4s_data_tvalid = (state_q == ST_DATA) && !fifo_empty;
      o_axi4s_data_tlast  = o_axi4s_data_tvalid && (cnt_q == CNT_LAST);
      o_axi4s_data_tdata  = '0;
      if (o_axi4s_data_tvalid) o_axi4s_data_tdata = {{DATAIN_WIDTH{1'b0}}, real_ext};
   end

   // Beat counter wraps naturally to 0 after the last beat; i_clr wins over
   // same-cycle overflow or frame-complete events.
   always_comb begin
      cnt_d     = data_hs ? cnt_q + LOGS_FFT_LEN'(1) : cnt_q;
      ovf_d     = ovf_q | smp_drop;
      frm_cnt_d = frm_cnt_q + 16'(tlast_hs);
      if (i_clr) begin
         ovf_d     = 1'b0;
         frm_cnt_d = '0;
      end
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         frm_cnt_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         frm_cnt_q <= frm_cnt_d;
      end
   end

   assign o_ovf     = ovf_q;
   assign o_frm_cnt = frm_cnt_q;
endmodule
